// File: rtl/cic_package.sv
`default_nettype none
// ============================================================================
// Module      : cic_package
// Description : Shared types and constants for the CIC decimator controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_package;

    localparam int CIC_BURST_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4
    } cic_ctrl_state_t;

    // Decimated outputs produced while the comb section is still filling.
    function automatic int warmup_len(input int m, input int g);
        return m * g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cic_out_fifo
// Description : Two-entry registered FIFO with push/pop, empty and drop flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_out_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout,
    output logic          o_empty,
    output logic          o_accept,
    output logic          o_drop
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_count;
    logic          w_pop;
    logic          w_full;

    assign w_pop    = i_pop && (r_count != 2'd0);
    assign w_full   = (r_count == 2'd2);
    // A full buffer still takes a sample when the head leaves the same cycle.
    assign o_accept = i_push && (!w_full || w_pop);
    assign o_drop   = i_push && !o_accept;
    assign o_empty  = (r_count == 2'd0);
    assign o_dout   = r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({o_accept, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_din;
                    else                 r_tail <= i_din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_d_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cic_d_ctrl
// Description : Sequencer that clears cic_d, skips its transient and buffers
//               settled samples for a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_d_ctrl
    import cic_package::*;
#(
    parameter int ODW        = 8,
    parameter int IDW        = 8,
    parameter int M          = 4,
    parameter int G          = 1,
    parameter int CLR_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CIC_BURST_W-1:0] burst_len,
    input  logic [IDW-1:0]         data_in,
    output logic [IDW-1:0]         cic_din,
    output logic                   cic_rst_n,
    input  logic                   cic_dv,
    input  logic [ODW-1:0]         cic_data,
    output logic [ODW-1:0]         out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int c_warm_len = warmup_len(M, G);
    localparam int c_warm_w   = $clog2(c_warm_len + 1);
    localparam int c_clr_w    = $clog2(CLR_CYCLES + 1);
    localparam logic [c_warm_w-1:0] c_warm_last = c_warm_w'(c_warm_len - 1);
    localparam logic [c_clr_w-1:0]  c_clr_last  = c_clr_w'(CLR_CYCLES - 1);

    cic_ctrl_state_t        r_state;
    logic [c_clr_w-1:0]     r_clr_cnt;
    logic [c_warm_w-1:0]    r_warm_cnt;
    logic [CIC_BURST_W-1:0] r_smp_cnt;
    logic [CIC_BURST_W-1:0] r_len;
    logic [CIC_BURST_W-1:0] w_smp_next;
    logic                   w_push;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_drop;

    assign w_push     = (r_state == ST_RUN) && cic_dv;
    assign w_smp_next = r_smp_cnt + CIC_BURST_W'(1);
    assign out_valid  = !w_empty;

    cic_out_fifo #(
        .DW (ODW)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .i_push   (w_push),
        .i_pop    (out_ready),
        .i_din    (cic_data),
        .o_dout   (out_data),
        .o_empty  (w_empty),
        .o_accept (w_accept),
        .o_drop   (w_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_warm_cnt <= '0;
            r_smp_cnt  <= '0;
            r_len      <= '0;
            cic_din    <= '0;
            cic_rst_n  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_drop) overflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_CLEAR;
                        busy       <= 1'b1;
                        r_len      <= burst_len;
                        overflow   <= 1'b0;
                        r_clr_cnt  <= '0;
                        r_warm_cnt <= '0;
                        r_smp_cnt  <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == c_clr_last) begin
                        r_state   <= ST_WARMUP;
                        cic_rst_n <= 1'b1;
                        cic_din   <= data_in;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_clr_w'(1);
                    end
                end
                ST_WARMUP: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                        cic_din <= '0;
                    end else begin
                        cic_din <= data_in;
                        if (cic_dv) begin
                            r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
                            if (r_warm_cnt == c_warm_last) r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cic_din <= data_in;
                    if (w_accept) r_smp_cnt <= w_smp_next;
                    // Only samples that actually entered the buffer count toward the burst.
                    if (stop || (w_accept && (r_len != '0) && (w_smp_next == r_len))) begin
                        r_state <= ST_DRAIN;
                        cic_din <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state   <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cic_rst_n <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_d_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_d_ctrl
// Description : Self-checking bench for cic_d_ctrl against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_d_ctrl;

    localparam int MG  = 4;
    localparam int CLR = 2;
    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_WARM  = 2;
    localparam int P_RUN   = 3;
    localparam int P_DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset, start, stop, cic_dv, out_ready;
    logic [15:0] burst_len;
    logic [7:0]  data_in, cic_data;
    logic [7:0]  cic_din, out_data;
    logic        cic_rst_n, out_valid, busy, done, overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dut_hs = 0;
    int dut_done = 0;

    int         ph = P_IDLE;
    int         clr_left, warm, cnt, len;
    bit         ovf = 1'b0;
    bit         done_e = 1'b0;
    logic [7:0] din_e = 8'h00;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    cic_d_ctrl #(
        .ODW (8), .IDW (8), .M (4), .G (1), .CLR_CYCLES (CLR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .burst_len (burst_len),
        .data_in   (data_in),
        .cic_din   (cic_din),
        .cic_rst_n (cic_rst_n),
        .cic_dv    (cic_dv),
        .cic_data  (cic_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: pick source stimulus, advance the model, then compare outputs.
    task automatic tick();
        bit pop, full, was_empty;
        int nph;
        cyc++;
        cic_dv   = (cyc % 4 == 0);
        cic_data = 8'($urandom);
        data_in  = 8'($urandom);
        if (out_valid && out_ready) dut_hs++;
        pop       = out_ready && (q.size() > 0);
        full      = (q.size() == 2);
        was_empty = (q.size() == 0);
        nph       = ph;
        done_e    = 1'b0;
        if (reset) begin
            nph = P_IDLE;
            q.delete();
            ovf = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            case (ph)
                P_IDLE: if (start) begin
                    nph = P_CLEAR; clr_left = CLR; len = int'(burst_len);
                    cnt = 0; warm = 0; ovf = 1'b0;
                end
                P_CLEAR: begin
                    clr_left--;
                    if (clr_left == 0) nph = P_WARM;
                end
                P_WARM: begin
                    if (stop) nph = P_DRAIN;
                    else if (cic_dv) begin
                        warm++;
                        if (warm == MG) nph = P_RUN;
                    end
                end
                P_RUN: begin
                    if (cic_dv) begin
                        if (!full || pop) begin
                            q.push_back(cic_data);
                            cnt++;
                            if (len != 0 && cnt == len) nph = P_DRAIN;
                        end else begin
                            ovf = 1'b1;
                        end
                    end
                    if (stop) nph = P_DRAIN;
                end
                P_DRAIN: if (was_empty) begin
                    nph = P_IDLE; done_e = 1'b1;
                end
                default: nph = P_IDLE;
            endcase
        end
        din_e = (nph == P_WARM || nph == P_RUN) ? data_in : 8'h00;
        ph = nph;
        @(posedge clk);
        #1;
        if (done) dut_done++;
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        chk("busy", busy, ph != P_IDLE);
        chk("done", done, done_e);
        chk("overflow", overflow, ovf);
        chk("cic_rst_n", cic_rst_n, ph >= P_WARM);
        chk("cic_din", cic_din, din_e);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 80 && ph != P_RUN; i++) tick();
        chk(tag, ph, P_RUN);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        for (int i = 0; i < maxc && ph != P_IDLE; i++) tick();
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        int hs0, d0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        burst_len = 16'd0; data_in = 8'h00; cic_dv = 1'b0; cic_data = 8'h00;
        repeat (3) tick();
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_rst_n", cic_rst_n, 1'b0);
        reset = 1'b0;
        tick();

        // Continuous run: clear window, warm-up skip, then streaming.
        burst_len = 16'd0;
        pulse_start();
        chk("clear_c1_low", cic_rst_n, 1'b0);
        tick();
        chk("clear_c2_low", cic_rst_n, 1'b0);
        tick();
        chk("warm_rst_high", cic_rst_n, 1'b1);
        wait_run("reach_run_a");
        repeat (24) tick();
        pulse_stop();
        wait_idle("idle_a", 40);

        // Fixed burst of three.
        hs0 = dut_hs; d0 = dut_done;
        burst_len = 16'd3;
        pulse_start();
        wait_idle("idle_burst3", 200);
        chk("burst3_delivered", dut_hs - hs0, 3);
        chk("burst3_done_once", dut_done - d0, 1);
        repeat (12) tick();
        chk("burst3_stays_idle", busy, 1'b0);
        chk("burst3_no_more", dut_hs - hs0, 3);

        // Back-pressure until a settled sample is dropped.
        out_ready = 1'b0; burst_len = 16'd0;
        pulse_start();
        wait_run("reach_run_ovf");
        for (int i = 0; i < 40 && !ovf; i++) tick();
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_buffer_held", out_valid, 1'b1);
        out_ready = 1'b1;
        repeat (3) tick();
        pulse_stop();
        wait_idle("idle_ovf", 40);

        // Stop with one buffered sample and the consumer stalled.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 80 && !(ph == P_RUN && q.size() == 1); i++) tick();
        chk("one_buffered", q.size(), 1);
        pulse_stop();
        repeat (6) tick();
        chk("stop_drain_busy", busy, 1'b1);
        chk("stop_drain_valid", out_valid, 1'b1);
        hs0 = dut_hs;
        out_ready = 1'b1;
        wait_idle("idle_stop", 20);
        chk("stop_one_handshake", dut_hs - hs0, 1);

        // Reset with a full buffer.
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 80 && q.size() != 2; i++) tick();
        chk("buffer_full", out_valid, 1'b1);
        reset = 1'b1;
        d0 = dut_done;
        tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cic_rst_n", cic_rst_n, 1'b0);
        chk("rst_no_done", dut_done - d0, 0);
        tick();

        // Stray start in RUN and stray stop in CLEAR.
        out_ready = 1'b1; burst_len = 16'd0;
        pulse_start();
        pulse_stop();
        chk("stop_in_clear_ignored", busy, 1'b1);
        wait_run("reach_run_ign");
        burst_len = 16'd1;
        pulse_start();
        repeat (12) tick();
        chk("start_in_run_ignored", busy, 1'b1);
        pulse_stop();
        wait_idle("idle_ign", 40);

        // Random bursts with a randomly stalling consumer.
        for (int r = 0; r < 4; r++) begin
            burst_len = 16'($urandom_range(2, 6));
            pulse_start();
            for (int i = 0; i < 400 && ph != P_IDLE; i++) begin
                out_ready = 1'($urandom);
                tick();
            end
            out_ready = 1'b1;
            wait_idle("idle_rand", 20);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cic_d_ctrl.md
# cic_d_ctrl

Sequencing controller for the CIC decimator (`cic_d`). It clears the decimator on command and gates its input while idle. It discards the first `m*g` decimated outputs, which are the filter transient, then delivers settled samples through a 2-entry valid/ready output buffer. It supports continuous or fixed-length bursts, and sits between the sample source, `cic_d`, and the downstream consumer.

## Interface
- `odw`, 8, CIC output data width (matches `cic_d` `odw`)
- `idw`, 8, CIC input data width
- `m`, 4, CIC order
- `g`, 1, comb differential delay
- `clr_cycles`, 2, cycles `cic_rst_n` is held low on start (≥1)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begins a run (honoured only in IDLE)
- `stop`  in  1  pulse; ends a run early (honoured in WARMUP/RUN)
- `burst_len`  in  16  samples to deliver; 0 = continuous; latched on accepted `start`
- `data_in`  in  idw  source samples, one per clock
- `cic_din`  out  idw  to `cic_d.data_in`
- `cic_rst_n`  out  1  to `cic_d.reset_n`
- `cic_dv`  in  1  from `cic_d.out_dv`
- `cic_data`  in  odw  from `cic_d.data_out`
- `out_data`  out  odw  head of output buffer
- `out_valid`  out  1  buffer non-empty
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on return to IDLE from DRAIN
- `overflow`  out  1  sticky; a settled sample was dropped

## Operation
- States: IDLE, CLEAR, WARMUP, RUN, DRAIN.
- IDLE: `cic_rst_n`=0, `cic_din`=0. `start` → CLEAR; latch `burst_len`; clear `overflow`, warm-up counter, sample counter.
- CLEAR: `cic_rst_n`=0, `cic_din`=0, for exactly `clr_cycles` cycles → WARMUP.
- WARMUP: `cic_rst_n`=1, `cic_din`=`data_in`. Count `cic_dv`; the first `m*g` pulses are discarded. The cycle carrying the `m*g`-th pulse → RUN. That pulse is not pushed.
- RUN: each `cic_dv` pushes `cic_data`. The sample counter increments on each successful push. When a push makes count == latched length (length ≠ 0) → DRAIN.
- `stop` in WARMUP/RUN → DRAIN. A `cic_dv` on the same cycle as `stop` in RUN is still pushed.
- DRAIN: `cic_rst_n`=1, `cic_din`=0. No pushes. When the buffer is empty → IDLE with `done`=1 for that one cycle.
- `start` outside IDLE, and `stop` in IDLE/CLEAR/DRAIN, are ignored.
- Buffer: 2 entries, FIFO order.
  - Push when full without a simultaneous pop → sample dropped, `overflow` set, sample counter not incremented.
  - Push + pop when full → both succeed.
  - Pop when empty → no effect.
- `cic_dv` is ignored in IDLE, CLEAR and DRAIN.

## Timing
- Reset values: state IDLE, `cic_rst_n`=0, `cic_din`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `overflow`=0, buffer empty.
- `reset` mid-run returns to IDLE the next cycle and empties the buffer. No `done` pulse.
- `start` at cycle t: `busy`=1 and `cic_rst_n`=0 from t+1. `cic_rst_n`=1 from t+1+`clr_cycles`.
- `cic_din` is registered: `data_in` at cycle t appears on `cic_din` at t+1 (WARMUP/RUN).
- Push latency: `cic_dv` at t gives `out_valid`=1 and `out_data` valid at t+1.
- Pop at t: the next entry (if any) is on `out_data` at t+1.
- `done` is asserted in the same cycle `busy` falls.
- `overflow` sets at t+1 after the dropping cycle and holds until the next accepted `start`.

## Structure
- `cic_package` gains:
  - the state enum typedef `cic_ctrl_state_t`;
  - a function `warmup_len(m,g)` returning `m*g`;
  - constant `CIC_BURST_W` = 16.
- One sub-module: `cic_out_fifo`, a 2-entry registered FIFO with push/pop, full/empty and drop indication.
- The FSM and counters live in `cic_d_ctrl`.
- Counters: warm-up `$clog2(m*g+1)` bits; sample counter `CIC_BURST_W` bits.

## Test plan
All scenarios use defaults (m=4, g=1, r=4), with the bench modelling `cic_dv` every 4th cycle.
- Reset then `start`: `cic_rst_n` low exactly 2 cycles. The first 4 `cic_dv` produce no `out_valid`. The 5th `cic_dv` gives `out_valid`=1 next cycle with the matching `cic_data`.
- `burst_len`=3, `out_ready`=1: exactly 3 samples delivered, then `done` pulses once and `busy`=0. Further `cic_dv` is ignored.
- `out_ready`=0 in RUN: 2 samples buffered; the 3rd `cic_dv` is dropped and `overflow`=1. After `out_ready`=1 the 2 samples drain in order.
- `stop` in RUN with 1 sample buffered and `out_ready`=0: state stays DRAIN. Raising `out_ready` gives one handshake, then `done`.
- `reset` asserted in RUN with a full buffer: next cycle `out_valid`=0, `busy`=0, `cic_rst_n`=0, no `done`.
- `start` during RUN and `stop` during CLEAR: both ignored, with no change in state sequence.
